// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t;

  localparam logic [31:0] IMEM_NOP = 32'hD503201F;

  function automatic int cnt_width(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

  // Wait counter must hold the largest legal wait value (7).
  localparam int CNT_W = cnt_width(7);

endpackage

// File: rtl/imem_array.sv
// Word array: one synchronous write port, one synchronous read port, read-before-write.
module imem_array #(
  parameter int DEPTH_LOG = 8
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [DEPTH_LOG-1:0] i_waddr,
  input  logic [31:0]          i_wdata,
  input  logic                 i_re,
  input  logic [DEPTH_LOG-1:0] i_raddr,
  output logic [31:0]          o_rdata
);

  logic [31:0] r_mem [0:(1<<DEPTH_LOG)-1];
  logic [31:0] r_rdata;

  // Same-edge read of a word being written returns the old contents.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory: one outstanding request, fixed WAIT+1 latency,
// misaligned/out-of-range addresses answered with a faulted NOP.
module imem_responder #(
  parameter int N         = 64,
  parameter int DEPTH_LOG = 8,
  parameter int WAIT      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid_F,
  input  logic [N-1:0]         imem_addr_F,
  output logic                 req_ready_F,
  output logic                 rsp_valid_F,
  output logic [31:0]          instr_F,
  output logic                 fault_F,
  input  logic                 ld_en,
  input  logic [DEPTH_LOG-1:0] ld_addr,
  input  logic [31:0]          ld_data,
  output logic                 busy
);
  // The WAIT parameter shadows the state literal of the same name, so that literal is package-qualified.
  import imem_pkg::imem_state_t;
  import imem_pkg::IDLE;
  import imem_pkg::RESP;
  import imem_pkg::IMEM_NOP;
  import imem_pkg::CNT_W;

  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT);

  imem_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [N-1:0]     r_addr;
  logic [N-1:0]     w_addr_cur;
  logic             w_accept, w_enter_resp, w_fault, w_rd_en;
  logic             r_fault, r_nop_sel;
  logic [31:0]      w_rdata;

  assign req_ready_F = (r_state != imem_pkg::WAIT);
  assign w_accept    = req_valid_F & req_ready_F;

  // With WAIT == 0 the read happens on the accept edge, so use the live address.
  assign w_addr_cur   = (r_state == imem_pkg::WAIT) ? r_addr : imem_addr_F;
  assign w_fault      = (|w_addr_cur[1:0]) | (|w_addr_cur[N-1:DEPTH_LOG+2]);
  assign w_enter_resp = (w_state_nxt == RESP);
  assign w_rd_en      = w_enter_resp & ~w_fault;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE, RESP: begin
        if (w_accept) begin
          w_cnt_nxt   = WAIT_CNT;
          w_state_nxt = (WAIT == 0) ? RESP : imem_pkg::WAIT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      imem_pkg::WAIT: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt <= 1) w_state_nxt = RESP;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_fault   <= 1'b0;
      r_nop_sel <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_enter_resp) begin
        r_fault   <= w_fault;
        r_nop_sel <= w_fault;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_addr <= imem_addr_F;
  end

  imem_array #(.DEPTH_LOG(DEPTH_LOG)) u_array (
    .clk     (clk),
    .i_we    (ld_en),
    .i_waddr (ld_addr),
    .i_wdata (ld_data),
    .i_re    (w_rd_en),
    .i_raddr (w_addr_cur[DEPTH_LOG+1:2]),
    .o_rdata (w_rdata)
  );

  assign instr_F     = r_nop_sel ? IMEM_NOP : w_rdata;
  assign fault_F     = r_fault;
  assign rsp_valid_F = (r_state == RESP);
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: three instances with WAIT = 1, 0 and 3.
module tb_imem_responder;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
    int          due;
  } exp_t;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        v   [3];
  logic [63:0] a   [3];
  logic        rdy [3];
  logic        rv  [3];
  logic        flt [3];
  logic        bsy [3];
  logic [31:0] ins [3];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  exp_t q0[$], q1[$], q2[$];
  logic [31:0] prog [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_responder #(.N(64), .DEPTH_LOG(8), .WAIT(1)) u_w1 (
    .clk(clk), .reset(reset), .req_valid_F(v[0]), .imem_addr_F(a[0]),
    .req_ready_F(rdy[0]), .rsp_valid_F(rv[0]), .instr_F(ins[0]), .fault_F(flt[0]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(bsy[0]));

  imem_responder #(.N(64), .DEPTH_LOG(8), .WAIT(0)) u_w0 (
    .clk(clk), .reset(reset), .req_valid_F(v[1]), .imem_addr_F(a[1]),
    .req_ready_F(rdy[1]), .rsp_valid_F(rv[1]), .instr_F(ins[1]), .fault_F(flt[1]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(bsy[1]));

  imem_responder #(.N(64), .DEPTH_LOG(8), .WAIT(3)) u_w3 (
    .clk(clk), .reset(reset), .req_valid_F(v[2]), .imem_addr_F(a[2]),
    .req_ready_F(rdy[2]), .rsp_valid_F(rv[2]), .instr_F(ins[2]), .fault_F(flt[2]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(bsy[2]));

  function automatic int wv(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic push(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic bit pop(input int i, output exp_t e);
    e = '{32'h0, 1'b0, 0};
    case (i)
      0: if (q0.size() != 0) begin e = q0.pop_front(); return 1'b1; end
      1: if (q1.size() != 0) begin e = q1.pop_front(); return 1'b1; end
      default: if (q2.size() != 0) begin e = q2.pop_front(); return 1'b1; end
    endcase
    return 1'b0;
  endfunction

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    bit   got;
    for (int i = 0; i < 3; i++) begin
      if (rv[i] === 1'b1) begin
        got = pop(i, e);
        if (!got) chk($sformatf("unexpected_rsp_u%0d", i), 32'd1, 32'd0);
        else begin
          chk($sformatf("instr_u%0d", i), ins[i], e.instr);
          chk($sformatf("fault_u%0d", i), {31'b0, flt[i]}, {31'b0, e.fault});
          chk($sformatf("latency_cycle_u%0d", i), cyc, e.due);
        end
      end
    end
  end

  task automatic issue(input int i, input logic [63:0] addr, input logic [31:0] ie, input logic fe);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    v[i] = 1'b1;
    a[i] = addr;
    while (rdy[i] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_timeout_u%0d: ready never seen, expected 1", i);
    end else begin
      e.instr = ie;
      e.fault = fe;
      e.due   = cyc + wv(i) + 1;
      push(i, e);
    end
  endtask

  task automatic idle(input int i);
    @(negedge clk);
    v[i] = 1'b0;
  endtask

  task automatic load(input logic [7:0] idx, input logic [31:0] d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = idx;
    ld_data = d;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("pending_responses", q0.size() + q1.size() + q2.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    prog[0] = 32'h8B020020;
    prog[1] = 32'h91001021;
    prog[2] = 32'hCB030041;
    prog[3] = 32'hD65F03C0;
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0;
      a[i] = '0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ready_u%0d", i), {31'b0, rdy[i]}, 32'd1);
      chk($sformatf("rst_rsp_valid_u%0d", i), {31'b0, rv[i]}, 32'd0);
      chk($sformatf("rst_instr_u%0d", i), ins[i], NOP);
      chk($sformatf("rst_fault_u%0d", i), {31'b0, flt[i]}, 32'd0);
      chk($sformatf("rst_busy_u%0d", i), {31'b0, bsy[i]}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 4; k++) load(8'(k), prog[k]);
    @(negedge clk);
    ld_en = 1'b0;

    // WAIT=1: four sequential fetches
    for (int k = 0; k < 4; k++) issue(0, 64'(4 * k), prog[k], 1'b0);
    idle(0);
    drain();

    // WAIT=0: back-to-back fetches, one response per cycle
    issue(1, 64'h0, prog[0], 1'b0);
    issue(1, 64'h4, prog[1], 1'b0);
    issue(1, 64'h8, prog[2], 1'b0);
    idle(1);
    drain();

    // Faults: misaligned and out of range
    issue(0, 64'h6, NOP, 1'b1);
    idle(0);
    issue(0, 64'h400, NOP, 1'b1);
    idle(0);
    issue(1, 64'h8000_0000_0000_0000, NOP, 1'b1);
    idle(1);
    drain();

    // WAIT=3: reset in the middle of an access drops it
    @(negedge clk);
    v[2] = 1'b1;
    a[2] = 64'h4;
    @(negedge clk);
    v[2] = 1'b0;
    chk("busy_in_wait", {31'b0, bsy[2]}, 32'd1);
    chk("ready_in_wait", {31'b0, rdy[2]}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rsp_valid_in_reset", {31'b0, rv[2]}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    chk("ready_after_reset", {31'b0, rdy[2]}, 32'd1);
    chk("busy_after_reset", {31'b0, bsy[2]}, 32'd0);
    repeat (8) @(negedge clk);
    issue(2, 64'h4, prog[1], 1'b0);
    idle(2);
    drain();

    // Load-port write to the word being read on the RESP-entry edge
    issue(0, 64'h4, prog[1], 1'b0);
    @(negedge clk);
    v[0]    = 1'b0;
    ld_en   = 1'b1;
    ld_addr = 8'd1;
    ld_data = 32'hAAAA5555;
    @(negedge clk);
    ld_en = 1'b0;
    drain();
    issue(0, 64'h4, 32'hAAAA5555, 1'b0);
    idle(0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
